// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART TX data-path stage. Captures a parallel word,
// computes its parity and shifts the data bits out LSB-first, one per clock.
//
// Ports:
//   CLK        in  TX bit clock, one bit slot per cycle
//   RST        in  asynchronous active-low reset
//   P_DATA     in  parallel data word (WIDTH bits)
//   DATA_VALID in  P_DATA valid this cycle; loads when ser_en is low
//   PAR_TYP    in  parity type, 0 = even, 1 = odd
//   ser_en     in  from TX FSM, high for start slot plus all data slots
//   ser_data   out current data bit (shift register bit 0)
//   ser_done   out high while the last data bit is on ser_data
//   par_bit    out parity of the captured word, stable until next load
//   ovr_err    out sticky: DATA_VALID seen while ser_en was high
module uart_tx_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_TYP,
    input  logic             ser_en,
    output logic             ser_data,
    output logic             ser_done,
    output logic             par_bit,
    output logic             ovr_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             ovr_q, ovr_d;
    logic             load;

    // A load is only accepted outside the start/data slots.
    assign load = DATA_VALID && !ser_en;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        ovr_d   = ovr_q;

        if (load) begin
            shift_d = P_DATA;
            par_d   = (^P_DATA) ^ PAR_TYP;
        end

        if (DATA_VALID && ser_en) begin
            ovr_d = 1'b1;
        end

        if (!ser_en) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            // Start slot: bit 0 is already presented, nothing to shift.
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            ovr_q   <= ovr_d;
        end
    end

    assign ser_data = shift_q[0];
    assign ser_done = ser_en && (cnt_q == CNT_LAST);
    assign par_bit  = par_q;
    assign ovr_err  = ovr_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized + directed bench for uart_tx_serializer
// with a frame-level reference model and per-cycle output comparison.
module tb_uart_tx_serializer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         DATA_VALID = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         ser_en = 1'b0;
    logic         ser_data, ser_done, par_bit, ovr_err;

    logic [4:0]   pd5 = '0;
    logic         dv5 = 1'b0, pt5 = 1'b0, en5 = 1'b0;
    logic         sd5, done5, par5, ovr5;

    int checks = 0;
    int errors = 0;

    uart_tx_serializer #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID), .PAR_TYP(PAR_TYP),
        .ser_en(ser_en), .ser_data(ser_data),
        .ser_done(ser_done), .par_bit(par_bit),
        .ovr_err(ovr_err)
    );

    uart_tx_serializer #(.WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(pd5),
        .DATA_VALID(dv5), .PAR_TYP(pt5),
        .ser_en(en5), .ser_data(sd5),
        .ser_done(done5), .par_bit(par5),
        .ovr_err(ovr5)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Frame-level model: captured word, number of bits already consumed,
    // and how many consecutive ser_en cycles the current window has run.
    int unsigned m_word = 0;
    int          m_used = 0;
    int          m_run = 0;
    logic        m_par = 1'b0;
    logic        m_ovr = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_word <= 0;
            m_used <= 0;
            m_run  <= 0;
            m_par  <= 1'b0;
            m_ovr  <= 1'b0;
        end else begin
            if (DATA_VALID && !ser_en) begin
                m_word <= 32'(P_DATA);
                m_used <= 0;
                m_par  <= (^P_DATA) ^ PAR_TYP;
            end
            if (DATA_VALID && ser_en) m_ovr <= 1'b1;
            if (ser_en) begin
                // Slot index within the window: 0 = start, 1..W = data.
                // Leaving data slot j (j<W) consumes one bit.
                if ((m_run % (W + 1)) >= 1 && (m_run % (W + 1)) <= W - 1)
                    m_used <= m_used + 1;
                m_run <= m_run + 1;
            end else begin
                m_run <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        logic e_data, e_done;
        e_data = (m_used < 32) ? m_word[m_used] : 1'b0;
        e_done = ser_en && ((m_run % (W + 1)) == W);
        chk("m_ser_data", 32'(ser_data), 32'(e_data));
        chk("m_ser_done", 32'(ser_done), 32'(e_done));
        chk("m_par_bit", 32'(par_bit), 32'(m_par));
        chk("m_ovr_err", 32'(ovr_err), 32'(m_ovr));
    end

    logic s_data, s_done, s_par, s_ovr;

    task automatic step(logic dv, logic [W-1:0] d, logic t, logic en);
        DATA_VALID = dv;
        P_DATA = d;
        PAR_TYP = t;
        ser_en = en;
        @(negedge CLK);
        s_data = ser_data;
        s_done = ser_done;
        s_par = par_bit;
        s_ovr = ovr_err;
        @(posedge CLK);
        #1;
    endtask

    task automatic window(int len, int ovr_k, logic [W-1:0] od,
                          output logic [W-1:0] bits,
                          output int done_k, output int done_n);
        bits = '0;
        done_k = -1;
        done_n = 0;
        for (int k = 0; k < len; k++) begin
            step(k == ovr_k, (k == ovr_k) ? od : '0, PAR_TYP, 1'b1);
            if (k >= 1 && k <= W) bits[k-1] = s_data;
            if (s_done) begin
                done_k = k;
                done_n++;
            end
        end
    endtask

    initial begin
        logic [W-1:0] bits;
        int dk, dn;
        logic [4:0] b5;
        int dk5;

        #1 RST = 1'b0;
        #1;
        chk("rst_ser_data", 32'(ser_data), 0);
        chk("rst_ser_done", 32'(ser_done), 0);
        chk("rst_par_bit", 32'(par_bit), 0);
        chk("rst_ovr_err", 32'(ovr_err), 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        step(0, '0, 0, 0);

        // 0xA5 even parity
        step(1, 8'hA5, 0, 0);
        window(W + 1, -1, '0, bits, dk, dn);
        chk("a5_bits", 32'(bits), 32'hA5);
        chk("a5_done_slot", 32'(dk), 8);
        chk("a5_done_count", 32'(dn), 1);
        step(0, '0, 0, 0);
        chk("a5_par", 32'(s_par), 0);

        // odd parity
        step(1, 8'h01, 1, 0);
        window(W + 1, -1, '0, bits, dk, dn);
        step(0, '0, 1, 0);
        chk("odd01_par_slot", 32'(s_par), 0);
        chk("odd01_bits", 32'(bits), 32'h01);
        step(1, 8'h03, 1, 0);
        step(0, '0, 1, 0);
        chk("odd03_par", 32'(s_par), 1);

        // back-to-back: second word loaded in the stop slot
        step(1, 8'hFF, 0, 0);
        window(W + 1, -1, '0, bits, dk, dn);
        chk("b2b_ff_bits", 32'(bits), 32'hFF);
        step(1, 8'h00, 0, 0);
        chk("b2b_ff_par", 32'(s_par), 0);
        window(W + 1, -1, '0, bits, dk, dn);
        chk("b2b_00_bits", 32'(bits), 0);
        chk("b2b_00_done_slot", 32'(dk), 8);
        chk("b2b_00_par", 32'(s_par), 0);

        // overrun during data bit 3
        step(1, 8'hA5, 0, 0);
        window(W + 1, 4, 8'h3C, bits, dk, dn);
        chk("ovr_bits", 32'(bits), 32'hA5);
        step(0, '0, 0, 0);
        chk("ovr_flag", 32'(s_ovr), 1);
        chk("ovr_par_kept", 32'(s_par), 0);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            int gap, len, ok;
            logic [W-1:0] d;
            logic t;
            d = W'($urandom);
            t = 1'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                step(1'($urandom_range(0, 3) == 0), W'($urandom), t, 0);
            step(1, d, t, 0);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, W)
                                              : W + 1;
            ok = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1)
                                             : -1;
            window(len, ok, W'($urandom), bits, dk, dn);
        end
        step(0, '0, 0, 0);
        chk("ovr_sticky", 32'(s_ovr), 1);

        // reset in the middle of a frame with cnt=4
        step(1, 8'hA5, 0, 0);
        for (int k = 0; k < 4; k++) step(0, '0, 0, 1);
        ser_en = 1'b1;
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_data", 32'(ser_data), 0);
        chk("mid_rst_done", 32'(ser_done), 0);
        chk("mid_rst_par", 32'(par_bit), 0);
        chk("mid_rst_ovr", 32'(ovr_err), 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, '0, 0, 1);
            chk("post_rst_done", 32'(s_done), 0);
        end
        step(0, '0, 0, 0);

        // a few more random frames after reset
        for (int n = 0; n < 20; n++) begin
            step(1, W'($urandom), 1'($urandom), 0);
            window(W + 1, -1, '0, bits, dk, dn);
        end
        step(0, '0, 0, 0);

        // WIDTH=5 instance
        dv5 = 1'b1;
        pd5 = 5'b10110;
        pt5 = 1'b0;
        @(posedge CLK);
        #1 dv5 = 1'b0;
        en5 = 1'b1;
        b5 = '0;
        dk5 = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k >= 1) b5[k-1] = sd5;
            if (done5) dk5 = k;
            @(posedge CLK);
            #1;
        end
        en5 = 1'b0;
        @(negedge CLK);
        chk("w5_bits", 32'(b5), 32'b10110);
        chk("w5_done_slot", 32'(dk5), 5);
        chk("w5_par", 32'(par5), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
